safe_stim_sequencer: RTL and testbench
======================================

# safe_stim_sequencer

Parametrised stimulus generator for the digital-safe output stage. It produces single-cycle clock-enable ticks in place of divided clocks, and drives `state`, `chance_count`, timer and BCD input-data buses to the feedback, servo, 7-segment and LCD blocks. In manual mode, values come from DIP switches. In auto mode, the block sweeps every FSM state with a programmable dwell time, a running mm:ss countdown and a BCD counter, so all output blocks can be exercised hands-free on the board.

## Interface
- `DIV_1K`, default 50000: clk cycles per `tick_1k` pulse (1 kHz at 50 MHz).
- `DIV_MUX`, default 100000: clk cycles per `tick_mux` pulse.
- `STATE_W`, default 4: width of the state bus.
- `NUM_STATES`, default 10: number of valid states, encoded 0..NUM_STATES-1.
- `CHANCE_MAX`, default 3: maximum chance count.
- `DWELL_MS`, default 2000: `tick_1k` pulses per state in auto mode.
- `START_MIN`, default 12: timer reload value for minutes.
- `START_SEC`, default 12: timer reload value for seconds.

Ports:
- `clk_50mhz` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `mode` in 1: 0 = manual, 1 = auto.
- `pause` in 1: auto mode only; freezes the dwell counter and timer.
- `btn_step` in 1: asynchronous button; each rising edge advances one state while paused.
- `dip_state` in STATE_W: manual state select.
- `dip_chance` in 4: manual chance select.
- `tick_1k` out 1: one-cycle enable pulse.
- `tick_mux` out 1: one-cycle enable pulse.
- `state` out STATE_W: state bus to the output blocks.
- `chance_count` out 4: chance count to the output blocks.
- `timer_min` out 6: countdown minutes.
- `timer_sec` out 6: countdown seconds.
- `input_data` out 16: 4-digit BCD value for the display.
- `sweep_done` out 1: one-cycle pulse on state wrap.

## Operation
- Tick dividers are free-running counters over 0..DIV-1. The tick is asserted for one cycle when the count equals DIV-1. Dividers run in both modes and while paused.
- `btn_step` passes through a 2-flop synchronizer plus an edge register. The rising edge is a one-cycle `step` strobe.
- Manual mode:
  - `state` is `dip_state` clamped to NUM_STATES-1.
  - `chance_count` is `dip_chance` clamped to CHANCE_MAX.
  - Timer holds at START_MIN:START_SEC; `input_data` holds 16'h1234.
- Auto mode, advance rule:
  - A 1 ms counter counts `tick_1k` pulses up to DWELL_MS-1.
  - `adv` fires on (counter expiry and not `pause`) or (`step` and `pause`).
  - A simultaneous expiry and `step` produce exactly one advance.
  - On `adv`, the dwell counter clears.
- Auto mode, effect of `adv`:
  - `state` increments; NUM_STATES-1 wraps to 0.
  - On wrap: pulse `sweep_done`, decrement `chance_count` (0 reloads to CHANCE_MAX), reload the timer to START_MIN:START_SEC.
  - `input_data` increments as a 4-digit BCD value. Each digit carries at 9; 9999 wraps to 0000.
- Timer in auto mode, not paused: one decrement per 1000 `tick_1k` pulses.
  - sec>0: decrement sec.
  - sec=0 and min>0: min-1, sec=59.
  - 00:00: saturate and hold.
- Manual-to-auto transition (`mode` sampled high after being low):
  - Dwell counter and seconds prescaler clear.
  - `state` and `chance_count` load from the clamped DIP values.
  - `input_data` loads 16'h0000.
- Auto-to-manual transition: outputs follow the manual rules from the next cycle.

## Timing
- Every output is registered. DIP-to-output latency is 1 cycle; the `btn_step`-to-advance latency is 3 cycles.
- Reset values, all taking effect on the first clk edge with `rst` high:
  - `tick_1k`, `tick_mux`, `sweep_done` = 0.
  - `state` = 0, `chance_count` = CHANCE_MAX.
  - Timer = START_MIN:START_SEC, `input_data` = 16'h0000.
  - All counters = 0.
- Reset mid-sweep or mid-count aborts immediately. The first `tick_1k` after release occurs DIV_1K cycles later.
- `sweep_done` is coincident with `state` = 0 after a wrap.
- Assertions:
  - `tick_*` is never high on two consecutive cycles.
  - `state` is always < NUM_STATES.
  - Each BCD digit is always ≤ 9.

## Structure
- Shared package `safe_pkg`, used by all output blocks:
  - `STATE_W`, `NUM_STATES`, `CHANCE_MAX`.
  - Named state constants.
  - `bcd4_inc` function.
- Sub-module `tick_div`, instantiated twice:
  - Parameter `DIV`, with a synchronous active-high `rst`.
  - Outputs a one-cycle `tick`.
- The top level holds the synchronizer, the advance logic, the timer and the BCD counter.

## Test plan
- DIV_1K=4, DIV_MUX=8: after reset release, `tick_1k` pulses every 4th cycle and `tick_mux` every 8th, each 1 cycle wide.
- Manual mode, `dip_state`=4'd13, `dip_chance`=4'd7: next cycle `state`=9 and `chance_count`=3.
- Auto mode, DWELL_MS=2, NUM_STATES=10: `state` steps 0→9→0 with one `sweep_done` pulse on the wrap; `chance_count` 3→2; `input_data` reads 16'h0010 after 10 advances.
- Paused, dwell expiry held off: one `btn_step` pulse advances `state` by exactly 1, 3 cycles after the edge. A step coincident with expiry also advances by exactly 1.
- Timer with START 0:01, 1000 ticks per second: goes 00:01→00:00 and holds. START 1:00 steps to 0:59.
- Assert `rst` mid-sweep at `state`=5: next cycle `state`=0, `chance_count`=3, timer 12:12, ticks low.

Source files
------------

// File: rtl/safe_pkg.sv
// ============================================================================
//  safe_pkg
//  Shared parameters, named FSM states and BCD helper for the safe output stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package safe_pkg;

    localparam int STATE_W    = 4;
    localparam int NUM_STATES = 10;
    localparam int CHANCE_MAX = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
    localparam logic [STATE_W-1:0] ST_ENTRY_1 = 4'd1;
    localparam logic [STATE_W-1:0] ST_ENTRY_2 = 4'd2;
    localparam logic [STATE_W-1:0] ST_ENTRY_3 = 4'd3;
    localparam logic [STATE_W-1:0] ST_ENTRY_4 = 4'd4;
    localparam logic [STATE_W-1:0] ST_CHECK   = 4'd5;
    localparam logic [STATE_W-1:0] ST_OPEN    = 4'd6;
    localparam logic [STATE_W-1:0] ST_WRONG   = 4'd7;
    localparam logic [STATE_W-1:0] ST_LOCKOUT = 4'd8;
    localparam logic [STATE_W-1:0] ST_ALARM   = 4'd9;

    // Four-digit BCD increment; 9999 rolls over to 0000.
    function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_div.sv
// ============================================================================
//  tick_div
//  Free-running divider producing a registered one-cycle enable every DIV clocks.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/safe_stim_sequencer.sv
// ============================================================================
//  safe_stim_sequencer
//  Manual/auto stimulus source for the safe's feedback, servo, 7-seg and LCD blocks.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module safe_stim_sequencer
    import safe_pkg::*;
#(
    parameter int DIV_1K     = 50000,
    parameter int DIV_MUX    = 100000,
    parameter int STATE_W    = safe_pkg::STATE_W,
    parameter int NUM_STATES = safe_pkg::NUM_STATES,
    parameter int CHANCE_MAX = safe_pkg::CHANCE_MAX,
    parameter int DWELL_MS   = 2000,
    parameter int START_MIN  = 12,
    parameter int START_SEC  = 12
) (
    input  logic               clk_50mhz,
    input  logic               rst,
    input  logic               mode,
    input  logic               pause,
    input  logic               btn_step,
    input  logic [STATE_W-1:0] dip_state,
    input  logic [3:0]         dip_chance,
    output logic               tick_1k,
    output logic               tick_mux,
    output logic [STATE_W-1:0] state,
    output logic [3:0]         chance_count,
    output logic [5:0]         timer_min,
    output logic [5:0]         timer_sec,
    output logic [15:0]        input_data,
    output logic               sweep_done
);

    localparam int                 DWELL_W    = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_MS - 1);
    localparam logic [9:0]         PRE_LAST   = 10'd999;
    localparam logic [STATE_W-1:0] STATE_LAST = STATE_W'(NUM_STATES - 1);
    localparam logic [3:0]         CHANCE_TOP = 4'(CHANCE_MAX);
    localparam logic [5:0]         MIN_INIT   = 6'(START_MIN);
    localparam logic [5:0]         SEC_INIT   = 6'(START_SEC);
    localparam logic [15:0]        MANUAL_BCD = 16'h1234;

    tick_div #(.DIV(DIV_1K)) u_div_1k (
        .clk  (clk_50mhz),
        .rst  (rst),
        .tick (tick_1k)
    );

    tick_div #(.DIV(DIV_MUX)) u_div_mux (
        .clk  (clk_50mhz),
        .rst  (rst),
        .tick (tick_mux)
    );

    logic               btn_meta;
    logic               btn_sync;
    logic               btn_prev;
    logic               mode_prev;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [9:0]         pre_cnt;

    logic               step;
    logic               expire;
    logic               adv;
    logic               wrap;
    logic               sec_tick;
    logic               run_tick;
    logic [STATE_W-1:0] dip_state_c;
    logic [3:0]         dip_chance_c;
    logic [5:0]         min_dec;
    logic [5:0]         sec_dec;

    assign step         = btn_sync & ~btn_prev;
    assign run_tick     = tick_1k & ~pause;
    assign expire       = tick_1k & (dwell_cnt == DWELL_LAST);
    // Pause swaps the advance source, so expiry and step can never both count.
    assign adv          = (expire & ~pause) | (step & pause);
    assign wrap         = adv & (state == STATE_LAST);
    assign sec_tick     = run_tick & (pre_cnt == PRE_LAST);
    assign dip_state_c  = (dip_state > STATE_LAST) ? STATE_LAST : dip_state;
    assign dip_chance_c = (dip_chance > CHANCE_TOP) ? CHANCE_TOP : dip_chance;

    always_comb begin
        min_dec = timer_min;
        sec_dec = timer_sec;
        if (timer_sec != 6'd0) begin
            sec_dec = timer_sec - 6'd1;
        end else if (timer_min != 6'd0) begin
            min_dec = timer_min - 6'd1;
            sec_dec = 6'd59;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            btn_meta     <= 1'b0;
            btn_sync     <= 1'b0;
            btn_prev     <= 1'b0;
            mode_prev    <= 1'b0;
            dwell_cnt    <= '0;
            pre_cnt      <= '0;
            state        <= STATE_W'(ST_IDLE);
            chance_count <= CHANCE_TOP;
            timer_min    <= MIN_INIT;
            timer_sec    <= SEC_INIT;
            input_data   <= 16'h0000;
            sweep_done   <= 1'b0;
        end else begin
            btn_meta   <= btn_step;
            btn_sync   <= btn_meta;
            btn_prev   <= btn_sync;
            mode_prev  <= mode;
            sweep_done <= 1'b0;

            if (!mode) begin
                dwell_cnt    <= '0;
                pre_cnt      <= '0;
                state        <= dip_state_c;
                chance_count <= dip_chance_c;
                timer_min    <= MIN_INIT;
                timer_sec    <= SEC_INIT;
                input_data   <= MANUAL_BCD;
            end else if (!mode_prev) begin
                dwell_cnt    <= '0;
                pre_cnt      <= '0;
                state        <= dip_state_c;
                chance_count <= dip_chance_c;
                input_data   <= 16'h0000;
            end else begin
                if (run_tick) begin
                    pre_cnt <= (pre_cnt == PRE_LAST) ? 10'd0 : pre_cnt + 10'd1;
                end

                if (adv) begin
                    dwell_cnt <= '0;
                end else if (run_tick) begin
                    dwell_cnt <= dwell_cnt + DWELL_W'(1);
                end

                if (adv) begin
                    input_data <= bcd4_inc(input_data);
                    if (wrap) begin
                        state        <= '0;
                        sweep_done   <= 1'b1;
                        chance_count <= (chance_count == 4'd0) ? CHANCE_TOP
                                                               : chance_count - 4'd1;
                    end else begin
                        state <= state + STATE_W'(1);
                    end
                end

                // A wrap restarts the countdown even if a second boundary lands on it.
                if (wrap) begin
                    timer_min <= MIN_INIT;
                    timer_sec <= SEC_INIT;
                end else if (sec_tick) begin
                    timer_min <= min_dec;
                    timer_sec <= sec_dec;
                end
            end
        end
    end

    a_tick_1k_single: assert property (@(posedge clk_50mhz) disable iff (rst)
        tick_1k |=> !tick_1k);
    a_tick_mux_single: assert property (@(posedge clk_50mhz) disable iff (rst)
        tick_mux |=> !tick_mux);
    a_state_range: assert property (@(posedge clk_50mhz) disable iff (rst)
        state <= STATE_LAST);
    a_bcd_digits: assert property (@(posedge clk_50mhz) disable iff (rst)
        (input_data[3:0] <= 4'd9) && (input_data[7:4] <= 4'd9) &&
        (input_data[11:8] <= 4'd9) && (input_data[15:12] <= 4'd9));

endmodule

`default_nettype wire

// File: tb/tb_safe_stim_sequencer.sv
// ============================================================================
//  tb_safe_stim_sequencer
//  Randomized bench for safe_stim_sequencer against a behavioural reference model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_safe_stim_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: fast sweep, driven randomly
    logic        a_rst, a_mode, a_pause, a_btn;
    logic [3:0]  a_dip_state, a_dip_chance;
    logic        a_tick_1k, a_tick_mux, a_sweep_done;
    logic [3:0]  a_state, a_chance;
    logic [5:0]  a_tmin, a_tsec;
    logic [15:0] a_data;

    // Instances B and C: long dwell so the countdown is observable
    logic        bc_rst;
    logic        bc_mode = 1'b1;
    logic        bc_pause = 1'b0;
    logic        bc_btn = 1'b0;
    logic [3:0]  bc_dip_state = 4'd0;
    logic [3:0]  bc_dip_chance = 4'd3;
    logic        b_tick_1k, b_tick_mux, b_sweep_done;
    logic [3:0]  b_state, b_chance;
    logic [5:0]  b_tmin, b_tsec;
    logic [15:0] b_data;
    logic        c_tick_1k, c_tick_mux, c_sweep_done;
    logic [3:0]  c_state, c_chance;
    logic [5:0]  c_tmin, c_tsec;
    logic [15:0] c_data;

    safe_stim_sequencer #(
        .DIV_1K(4), .DIV_MUX(8), .STATE_W(4), .NUM_STATES(10), .CHANCE_MAX(3),
        .DWELL_MS(2), .START_MIN(12), .START_SEC(12)
    ) dut (
        .clk_50mhz(clk), .rst(a_rst), .mode(a_mode), .pause(a_pause), .btn_step(a_btn),
        .dip_state(a_dip_state), .dip_chance(a_dip_chance),
        .tick_1k(a_tick_1k), .tick_mux(a_tick_mux), .state(a_state),
        .chance_count(a_chance), .timer_min(a_tmin), .timer_sec(a_tsec),
        .input_data(a_data), .sweep_done(a_sweep_done)
    );

    safe_stim_sequencer #(
        .DIV_1K(2), .DIV_MUX(3), .STATE_W(4), .NUM_STATES(10), .CHANCE_MAX(3),
        .DWELL_MS(600), .START_MIN(0), .START_SEC(1)
    ) dut_b (
        .clk_50mhz(clk), .rst(bc_rst), .mode(bc_mode), .pause(bc_pause), .btn_step(bc_btn),
        .dip_state(bc_dip_state), .dip_chance(bc_dip_chance),
        .tick_1k(b_tick_1k), .tick_mux(b_tick_mux), .state(b_state),
        .chance_count(b_chance), .timer_min(b_tmin), .timer_sec(b_tsec),
        .input_data(b_data), .sweep_done(b_sweep_done)
    );

    safe_stim_sequencer #(
        .DIV_1K(2), .DIV_MUX(4), .STATE_W(4), .NUM_STATES(10), .CHANCE_MAX(3),
        .DWELL_MS(600), .START_MIN(1), .START_SEC(0)
    ) dut_c (
        .clk_50mhz(clk), .rst(bc_rst), .mode(bc_mode), .pause(bc_pause), .btn_step(bc_btn),
        .dip_state(bc_dip_state), .dip_chance(bc_dip_chance),
        .tick_1k(c_tick_1k), .tick_mux(c_tick_mux), .state(c_state),
        .chance_count(c_chance), .timer_min(c_tmin), .timer_sec(c_tsec),
        .input_data(c_data), .sweep_done(c_sweep_done)
    );

    // ---------------- behavioural reference model ----------------
    localparam int NS   = 10;
    localparam int CMAX = 3;
    int P_DIV1K[3]  = '{4, 2, 2};
    int P_DIVMUX[3] = '{8, 3, 4};
    int P_DWELL[3]  = '{2, 600, 600};
    int P_START[3]  = '{12*60 + 12, 1, 60};

    bit m_valid[3] = '{0, 0, 0};
    int m_n[3], m_st[3], m_ch[3], m_tot[3], m_data[3], m_dwell[3], m_pre[3];
    bit m_sweep[3], m_prev[3], m_b1[3], m_b2[3], m_b3[3];

    task automatic model_step(input int k, input logic rst, input logic mode,
                              input logic pause, input logic btn,
                              input logic [3:0] ds, input logic [3:0] dc);
        bit tick_in, step, expire, adv;
        int cs, cc;
        if (rst) begin
            m_valid[k] = 1; m_n[k] = 0; m_st[k] = 0; m_ch[k] = CMAX;
            m_tot[k] = P_START[k]; m_data[k] = 0; m_dwell[k] = 0; m_pre[k] = 0;
            m_sweep[k] = 0; m_prev[k] = 0; m_b1[k] = 0; m_b2[k] = 0; m_b3[k] = 0;
            return;
        end
        tick_in = (m_n[k] > 0) && (m_n[k] % P_DIV1K[k] == 0);
        step    = m_b2[k] && !m_b3[k];
        cs      = (ds > 4'd9) ? 9 : int'(ds);
        cc      = (dc > 4'd3) ? 3 : int'(dc);
        m_sweep[k] = 0;
        if (!mode) begin
            m_st[k] = cs; m_ch[k] = cc; m_tot[k] = P_START[k]; m_data[k] = 1234;
            m_dwell[k] = 0; m_pre[k] = 0;
        end else if (!m_prev[k]) begin
            m_st[k] = cs; m_ch[k] = cc; m_data[k] = 0; m_dwell[k] = 0; m_pre[k] = 0;
        end else begin
            expire = tick_in && (m_dwell[k] == P_DWELL[k] - 1);
            adv    = pause ? step : expire;
            if (tick_in && !pause) begin
                if (m_pre[k] == 999 && m_tot[k] > 0) m_tot[k]--;
                m_pre[k] = (m_pre[k] + 1) % 1000;
            end
            if (adv) m_dwell[k] = 0;
            else if (tick_in && !pause) m_dwell[k]++;
            if (adv) begin
                m_data[k] = (m_data[k] + 1) % 10000;
                if (m_st[k] == NS - 1) begin
                    m_st[k] = 0; m_sweep[k] = 1; m_tot[k] = P_START[k];
                    m_ch[k] = (m_ch[k] == 0) ? CMAX : m_ch[k] - 1;
                end else begin
                    m_st[k]++;
                end
            end
        end
        m_b3[k] = m_b2[k]; m_b2[k] = m_b1[k]; m_b1[k] = btn;
        m_prev[k] = mode;
        m_n[k]++;
    endtask

    function automatic logic [15:0] to_bcd(input int d);
        logic [15:0] r;
        r[15:12] = 4'((d / 1000) % 10);
        r[11:8]  = 4'((d / 100) % 10);
        r[7:4]   = 4'((d / 10) % 10);
        r[3:0]   = 4'(d % 10);
        return r;
    endfunction

    function automatic logic [38:0] model_vec(input int k);
        logic t1, tm;
        t1 = (m_n[k] > 0) && (m_n[k] % P_DIV1K[k] == 0);
        tm = (m_n[k] > 0) && (m_n[k] % P_DIVMUX[k] == 0);
        return {t1, tm, m_sweep[k], 4'(m_st[k]), 4'(m_ch[k]),
                6'(m_tot[k] / 60), 6'(m_tot[k] % 60), to_bcd(m_data[k])};
    endfunction

    always @(posedge clk) begin
        model_step(0, a_rst, a_mode, a_pause, a_btn, a_dip_state, a_dip_chance);
        for (int k = 1; k < 3; k++)
            model_step(k, bc_rst, bc_mode, bc_pause, bc_btn, bc_dip_state, bc_dip_chance);
    end

    task automatic check_vec(input int k, input logic [38:0] got);
        logic [38:0] exp_v;
        exp_v = model_vec(k);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL model_inst%0d t=%0t got=%h exp=%h (tick1k,tickmux,sweep,state,chance,min,sec,data)",
                     k, $time, got, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid[0])
            check_vec(0, {a_tick_1k, a_tick_mux, a_sweep_done, a_state, a_chance, a_tmin, a_tsec, a_data});
        if (m_valid[1])
            check_vec(1, {b_tick_1k, b_tick_mux, b_sweep_done, b_state, b_chance, b_tmin, b_tsec, b_data});
        if (m_valid[2])
            check_vec(2, {c_tick_1k, c_tick_mux, c_sweep_done, c_state, c_chance, c_tmin, c_tsec, c_data});
    end

    task automatic check_lit(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
        end
    endtask

    // ---------------- timer instances B/C ----------------
    bit bc_done = 0;
    initial begin
        bit found;
        wait (bc_rst == 1'b0);
        @(negedge clk);
        check_lit("b_start_min", b_tmin, 0);
        check_lit("b_start_sec", b_tsec, 1);
        check_lit("c_start_min", c_tmin, 1);
        check_lit("c_start_sec", c_tsec, 0);
        found = 0;
        for (int i = 0; i < 2600; i++) begin
            @(negedge clk);
            if (b_tsec == 6'd0) begin
                found = 1;
                break;
            end
        end
        check_lit("b_reach_zero", int'(found), 1);
        check_lit("b_zero_min", b_tmin, 0);
        check_lit("c_borrow_min", c_tmin, 0);
        check_lit("c_borrow_sec", c_tsec, 59);
        repeat (2200) @(negedge clk);
        check_lit("b_hold_min", b_tmin, 0);
        check_lit("b_hold_sec", b_tsec, 0);
        check_lit("c_next_sec", c_tsec, 58);
        bc_done = 1;
    end

    // ---------------- main stimulus for instance A ----------------
    initial begin
        int first, n1k, nmux, sweeps, s0;
        bit found;
        a_rst = 1; a_mode = 0; a_pause = 0; a_btn = 0;
        a_dip_state = 0; a_dip_chance = 0; bc_rst = 1;
        repeat (2) @(negedge clk);
        check_lit("rst_state", a_state, 0);
        check_lit("rst_chance", a_chance, 3);
        check_lit("rst_timer", {a_tmin, a_tsec}, {6'd12, 6'd12});
        check_lit("rst_data", a_data, 0);
        check_lit("rst_ticks", {a_tick_1k, a_tick_mux, a_sweep_done}, 0);

        a_rst = 0; bc_rst = 0; a_dip_state = 4'd13; a_dip_chance = 4'd7;
        first = -1; n1k = 0; nmux = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check_lit("manual_state_clamp", a_state, 9);
                check_lit("manual_chance_clamp", a_chance, 3);
                check_lit("manual_data", a_data, 16'h1234);
            end
            if (a_tick_1k) begin
                n1k++;
                if (first < 0) first = i;
            end
            if (a_tick_mux) nmux++;
        end
        check_lit("first_tick_1k", first, 4);
        check_lit("tick_1k_count", n1k, 8);
        check_lit("tick_mux_count", nmux, 4);

        a_dip_state = 0; a_dip_chance = 3; a_mode = 1;
        sweeps = 0; found = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (a_sweep_done) sweeps++;
            if (a_data == 16'h0010) begin
                found = 1;
                break;
            end
        end
        check_lit("sweep_reach_10", int'(found), 1);
        check_lit("sweep_pulses", sweeps, 1);
        check_lit("sweep_coincident", {a_sweep_done, a_state}, {1'b1, 4'd0});
        check_lit("sweep_chance", a_chance, 2);

        a_pause = 1;
        repeat (4) @(negedge clk);
        s0 = a_state;
        a_btn = 1;
        repeat (2) begin
            @(negedge clk);
            check_lit("step_early", a_state, s0);
        end
        @(negedge clk);
        check_lit("step_latency3", a_state, (s0 + 1) % 10);
        repeat (6) @(negedge clk);
        check_lit("step_once", a_state, (s0 + 1) % 10);
        a_btn = 0;

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            a_rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 199) == 0) a_mode = ~a_mode;
            if ($urandom_range(0, 39) == 0) a_pause = ~a_pause;
            if ($urandom_range(0, 5) == 0) a_btn = ~a_btn;
            if ($urandom_range(0, 49) == 0) begin
                a_dip_state  = 4'($urandom_range(0, 15));
                a_dip_chance = 4'($urandom_range(0, 15));
            end
        end

        @(negedge clk);
        a_rst = 0; a_mode = 1; a_pause = 0; a_btn = 0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_state == 4'd5) begin
                found = 1;
                break;
            end
        end
        check_lit("reach_state5", int'(found), 1);
        a_rst = 1;
        @(negedge clk);
        check_lit("midrst_state", a_state, 0);
        check_lit("midrst_chance", a_chance, 3);
        check_lit("midrst_timer", {a_tmin, a_tsec}, {6'd12, 6'd12});
        check_lit("midrst_ticks", {a_tick_1k, a_tick_mux}, 0);
        a_rst = 0;

        for (int i = 0; i < 6000 && !bc_done; i++) @(negedge clk);
        check_lit("bc_finished", int'(bc_done), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
